// File: rtl/inttofp_pkg.sv
`default_nettype none
// ============================================================================
// inttofp_pkg : control-bit indices, float format constants, lane helpers
// Revision    : 1.0
// ============================================================================
package inttofp_pkg;

    localparam int VALID    = 5;
    localparam int SRC32    = 4;
    localparam int DST32    = 3;
    localparam int SIGNED   = 2;
    localparam int SRC_HIGH = 1;
    localparam int DST_HIGH = 0;

    localparam int FP32_BIAS  = 127;
    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP16_BIAS  = 15;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

    // Encoded as {src_is_32, dst_is_32}.
    typedef enum logic [1:0] {
        MODE_16_16 = 2'b00,
        MODE_16_32 = 2'b01,
        MODE_32_16 = 2'b10,
        MODE_32_32 = 2'b11
    } mode_e;

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return sgn ? {{16{h[15]}}, h} : {16'h0000, h};
    endfunction

endpackage
`default_nettype wire

// File: rtl/inttofp_lane_cvt.sv
`default_nettype none
// ============================================================================
// itf_lane_cvt : 32-bit int/uint to fp32 or fp16, round-to-nearest-even
// Revision     : 1.0
// ============================================================================
module itf_lane_cvt
    import inttofp_pkg::*;
(
    input  logic [31:0] int_i,
    input  logic        signed_i,
    input  logic        fp16_i,
    output logic [31:0] fp_o
);

    logic        w_sign;
    logic [31:0] w_mag;
    logic [4:0]  w_lzc;
    logic [4:0]  w_msb;
    logic [31:0] w_norm;
    logic        w_rup32;
    logic        w_rup16;
    logic [30:0] w_sum32;
    logic [15:0] w_sum16;
    logic        w_ovf16;
    logic        w_unused;

    always_comb begin
        w_sign = signed_i & int_i[31];
        w_mag  = w_sign ? (~int_i + 32'd1) : int_i;
        w_lzc  = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (w_mag[i]) w_lzc = 5'(31 - i);
        end
        w_msb  = 5'd31 - w_lzc;
        w_norm = w_mag << w_lzc;

        // Adding the round bit across {exp, mantissa} lets a mantissa carry bump the exponent.
        w_rup32 = w_norm[7] & ((|w_norm[6:0]) | w_norm[8]);
        w_sum32 = {8'(FP32_BIAS) + {3'b000, w_msb}, w_norm[30:8]} + {30'd0, w_rup32};

        w_rup16 = w_norm[20] & ((|w_norm[19:0]) | w_norm[21]);
        w_sum16 = {6'(FP16_BIAS) + {1'b0, w_msb}, w_norm[30:21]} + {15'd0, w_rup16};
        w_ovf16 = (w_sum16[15:10] >= 6'd31);

        if (w_mag == 32'd0) begin
            fp_o = 32'd0;
        end else if (fp16_i) begin
            fp_o = {16'h0000, w_sign, w_ovf16 ? FP16_INF_MAG : w_sum16[14:0]};
        end else begin
            fp_o = {w_sign, w_sum32};
        end
    end

    assign w_unused = w_norm[31];

endmodule
`default_nettype wire

// File: rtl/inttofp.sv
`default_nettype none
// ============================================================================
// inttofp : packed int16/int32 to fp16/fp32 vector converter, 1-cycle latency
// Revision: 1.0
// ============================================================================
module inttofp
    import inttofp_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] dvr_inttofp_s,
    input  logic [5:0]   cru_inttofp,
    output logic [127:0] dr_inttofp_d
);

    mode_e        w_mode;
    logic         w_sgn;
    logic [31:0]  w_wide_in  [4];
    logic [31:0]  w_wide_fp  [4];
    logic [31:0]  w_narrow_fp[4];
    logic [127:0] w_res_d;
    logic [127:0] r_res_q;
    logic         w_unused;

    assign w_mode = mode_e'({cru_inttofp[SRC32], cru_inttofp[DST32]});
    assign w_sgn  = cru_inttofp[SIGNED];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            case (w_mode)
                MODE_32_32: w_wide_in[i] = dvr_inttofp_s[32*i +: 32];
                MODE_16_16: w_wide_in[i] = ext16(dvr_inttofp_s[16*i +: 16], w_sgn);
                MODE_16_32: w_wide_in[i] = ext16(dvr_inttofp_s[32*i + 16*int'(cru_inttofp[SRC_HIGH]) +: 16], w_sgn);
                default:    w_wide_in[i] = ext16(dvr_inttofp_s[32*i + 16*int'(cru_inttofp[DST_HIGH]) +: 16], w_sgn);
            endcase
        end
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_wide
            itf_lane_cvt u_cvt (
                .int_i    (w_wide_in[g]),
                .signed_i (w_sgn),
                .fp16_i   (~cru_inttofp[DST32]),
                .fp_o     (w_wide_fp[g])
            );
        end
        // Upper four fp16 lanes only matter in 16->16 mode.
        for (genvar g = 0; g < 4; g++) begin : g_narrow
            itf_lane_cvt u_cvt (
                .int_i    (ext16(dvr_inttofp_s[16*(g+4) +: 16], w_sgn)),
                .signed_i (w_sgn),
                .fp16_i   (1'b1),
                .fp_o     (w_narrow_fp[g])
            );
        end
    endgenerate

    always_comb begin
        w_res_d = 128'd0;
        for (int i = 0; i < 4; i++) begin
            case (w_mode)
                MODE_16_16: begin
                    w_res_d[16*i +: 16]     = w_wide_fp[i][15:0];
                    w_res_d[16*(i+4) +: 16] = w_narrow_fp[i][15:0];
                end
                MODE_32_16: w_res_d[16*i +: 16] = w_wide_fp[i][15:0];
                default:    w_res_d[32*i +: 32] = w_wide_fp[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_q <= 128'd0;
        end else if (cru_inttofp[VALID]) begin
            r_res_q <= w_res_d;
        end
    end

    assign dr_inttofp_d = r_res_q;

    assign w_unused = ^{w_narrow_fp[0][31:16], w_narrow_fp[1][31:16],
                        w_narrow_fp[2][31:16], w_narrow_fp[3][31:16]};

endmodule
`default_nettype wire

// File: tb/tb_inttofp.sv
`default_nettype none
// ============================================================================
// tb_inttofp : scoreboard bench, directed vectors plus randomized model check
// Revision   : 1.0
// ============================================================================
module tb_inttofp;

    logic         clk;
    logic         rst_n;
    logic [127:0] dvr_inttofp_s;
    logic [5:0]   cru_inttofp;
    logic [127:0] dr_inttofp_d;

    inttofp u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .dvr_inttofp_s (dvr_inttofp_s),
        .cru_inttofp   (cru_inttofp),
        .dr_inttofp_d  (dr_inttofp_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] exp;
        string        name;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [127:0] model_q;
    int           n_vec;
    int           n_bad;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent reference: explicit remainder-vs-half rounding.
    function automatic logic [31:0] ref_cvt(input logic [31:0] v, input bit sg, input bit h);
        bit neg;
        longint unsigned mag, q, rem, half;
        int msb, mb, sh;
        neg = sg && v[31];
        mag = neg ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
        if (mag == 0) return 32'd0;
        msb = 0;
        for (int i = 0; i < 33; i++) if (((mag >> i) & 64'd1) != 0) msb = i;
        mb = h ? 10 : 23;
        if (msb <= mb) begin
            q = mag << (mb - msb);
        end else begin
            sh   = msb - mb;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == (64'd1 << (mb + 1))) begin
                q   = q >> 1;
                msb = msb + 1;
            end
        end
        if (h) begin
            if (msb > 15) return {16'h0, neg, 15'h7C00};
            return {16'h0, neg, 5'(msb + 15), 10'(q)};
        end
        return {neg, 8'(msb + 127), 23'(q)};
    endfunction

    function automatic logic [31:0] sx(input logic [15:0] hw, input bit sg);
        return sg ? {{16{hw[15]}}, hw} : {16'h0, hw};
    endfunction

    function automatic logic [127:0] ref_top(input logic [127:0] d, input logic [5:0] c);
        logic [127:0] r;
        logic [31:0]  t;
        logic [15:0]  hw;
        bit           sg;
        r  = 128'd0;
        sg = c[2];
        case ({c[4], c[3]})
            2'b11: for (int i = 0; i < 4; i++) r[32*i +: 32] = ref_cvt(d[32*i +: 32], sg, 1'b0);
            2'b00: for (int i = 0; i < 8; i++) begin
                t = ref_cvt(sx(d[16*i +: 16], sg), sg, 1'b1);
                r[16*i +: 16] = t[15:0];
            end
            2'b01: for (int i = 0; i < 4; i++) begin
                hw = d[16*(2*i + int'(c[1])) +: 16];
                r[32*i +: 32] = ref_cvt(sx(hw, sg), sg, 1'b0);
            end
            default: for (int i = 0; i < 4; i++) begin
                hw = c[0] ? d[32*i + 16 +: 16] : d[32*i +: 16];
                t  = ref_cvt(sx(hw, sg), sg, 1'b1);
                r[16*i +: 16] = t[15:0];
            end
        endcase
        return r;
    endfunction

    task automatic drive(input string name, input logic [127:0] data, input logic [5:0] ctrl,
                         input logic [127:0] exp);
        exp_t e;
        @(negedge clk);
        dvr_inttofp_s = data;
        cru_inttofp   = ctrl;
        if (ctrl[5]) model_q = exp;
        e.exp  = model_q;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check(mon_e.name, dr_inttofp_d, mon_e.exp);
        end
    end

    initial begin
        logic [127:0] rd;
        logic [5:0]   rc;
        n_vec         = 0;
        n_bad         = 0;
        model_q       = 128'd0;
        rst_n         = 1'b0;
        dvr_inttofp_s = 128'd0;
        cru_inttofp   = 6'd0;

        repeat (2) @(posedge clk);
        #1 check("reset_zero", dr_inttofp_d, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive("s32_to_f32", {32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000001}, 6'b111100,
              {32'hCF000000, 32'h4F000000, 32'hBF800000, 32'h3F800000});
        drive("u32_to_f32", {32'hFFFFFFFF, 32'h00000000, 32'h01000001, 32'h01000003}, 6'b111000,
              {32'h4F800000, 32'h00000000, 32'h4B800000, 32'h4B800002});
        drive("s16_to_f16", {16'hFC00, 16'h0803, 16'h0801, 16'h0001, 16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF},
              6'b100100,
              {16'hE400, 16'h6802, 16'h6800, 16'h3C00, 16'h0000, 16'hBC00, 16'hF800, 16'h7800});
        drive("u16_to_f16", {16'h0000, 16'h0000, 16'h0002, 16'h8000, 16'hFFF0, 16'hFFEF, 16'hFFE0, 16'hFFFF},
              6'b100000,
              {16'h0000, 16'h0000, 16'h4000, 16'h7800, 16'h7C00, 16'h7BFF, 16'h7BFF, 16'h7C00});
        drive("s16_to_f32_hi", {32'hFFFF0000, 96'd0}, 6'b101110, {32'hBF800000, 96'd0});
        drive("s16_to_f32_lo", {32'h0, 32'h0, 32'h12348000, 32'h7FFF0005}, 6'b101100,
              {32'h0, 32'h0, 32'hC7000000, 32'h40A00000});
        drive("s32_to_f16_hi", {32'h7FFF0000, 32'h0, 32'h0, 32'h00010000}, 6'b110011,
              {64'h0, 16'h7800, 16'h0000, 16'h0000, 16'h3C00});
        drive("s32_to_f16_lo", {32'h80000000, 32'h1234FFFF, 32'h0, 32'h0}, 6'b110100,
              {64'h0, 16'h0000, 16'hBC00, 16'h0000, 16'h0000});
        drive("f32_hilo_ignored", {96'd0, 32'h00000002}, 6'b111111, {96'd0, 32'h40000000});
        drive("hold_valid0", {32'h12345678, 96'd7}, 6'b011100, 128'd0);
        drain();

        @(negedge clk);
        cru_inttofp = 6'd0;
        #2 rst_n = 1'b0;
        #1 check("async_reset", dr_inttofp_d, 128'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        model_q = 128'd0;
        drive("post_reset_idle", {32'h00000001, 96'd1}, 6'b011100, 128'd0);
        drive("post_reset_first", {96'd0, 32'h00000001}, 6'b111100, {96'd0, 32'h3F800000});

        for (int n = 0; n < 100; n++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            rc = {($urandom_range(0, 7) != 0), 5'($urandom)};
            drive($sformatf("rand_%0d", n), rd, rc, ref_top(rd, rc));
        end
        drain();

        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d pending expected %0d", sb.size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
